// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared state encoding and constants for the stopwatch control.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } sw_state_t;

    localparam int unsigned c_DEBOUNCE_CYCLES = 20;
    localparam int unsigned c_AT_MAX_COUNT    = 59999;
    localparam int unsigned c_DEBOUNCE_CNT_W  = 8;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Active-low key synchronizer, debouncer and press-pulse generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n_i,
    output logic press_o
);

    localparam logic [c_DEBOUNCE_CNT_W-1:0] c_CNT_LAST =
        c_DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                        sync1_q;
    logic                        sync2_q;
    logic                        level_q;
    logic                        level_d;
    logic                        press_q;
    logic                        press_d;
    logic [c_DEBOUNCE_CNT_W-1:0] cnt_q;
    logic [c_DEBOUNCE_CNT_W-1:0] cnt_d;

    // Any sample that agrees with the accepted level restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == c_CNT_LAST) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Start/stop/lap control FSM for the stopwatch counter.
//                Lap-freeze feature enabled by STOPWATCH_LAP_HOLD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    input  logic       at_max,
    output logic       enable,
    output logic       reset_counter,
    output logic       freeze,
    output logic [1:0] state
);

    sw_state_t state_q;
    sw_state_t state_d;
    logic      rstc_q;
    logic      rstc_d;
    logic      w_start_press;
    logic      w_lap_press;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_start (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_start_n),
        .press_o (w_start_press)
    );

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_lap (
        .clk     (clk),
        .rst     (rst),
        .key_n_i (key_lap_n),
        .press_o (w_lap_press)
    );

    // Lap doubles as clear everywhere except RUN, where it only affects freeze.
    always_comb begin
        state_d = state_q;
        rstc_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_lap_press) begin
                    rstc_d = 1'b1;
                end else if (w_start_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (at_max) begin
                    state_d = ST_DONE;
                end else if (w_start_press) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (w_lap_press) begin
                    state_d = ST_IDLE;
                    rstc_d  = 1'b1;
                end else if (w_start_press) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (w_lap_press) begin
                    state_d = ST_IDLE;
                    rstc_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rstc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rstc_q  <= rstc_d;
        end
    end

`ifdef STOPWATCH_LAP_HOLD_EN
    logic freeze_q;
    logic freeze_d;

    // Freeze only survives in RUN and PAUSE; leaving for DONE/IDLE drops it.
    always_comb begin
        freeze_d = freeze_q;
        case (state_q)
            ST_RUN: begin
                if (at_max) begin
                    freeze_d = 1'b0;
                end else if (!w_start_press && w_lap_press) begin
                    freeze_d = ~freeze_q;
                end
            end
            ST_PAUSE: begin
                if (w_lap_press) begin
                    freeze_d = 1'b0;
                end
            end
            default: begin
                freeze_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze_d;
        end
    end

    assign freeze = freeze_q;
`else
    assign freeze = 1'b0;
`endif

    assign enable        = (state_q == ST_RUN);
    assign reset_counter = rstc_q;
    assign state         = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_ctrl
//  Description : Directed self-checking bench for stopwatch_ctrl (DEBOUNCE_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam logic c_HOLD = 1'b1;
`else
    localparam logic c_HOLD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       key_start_n;
    logic       key_lap_n;
    logic       at_max;
    logic       enable;
    logic       reset_counter;
    logic       freeze;
    logic [1:0] state;

    int checks = 0;
    int errors = 0;

    stopwatch_ctrl #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_start_n   (key_start_n),
        .key_lap_n     (key_lap_n),
        .at_max        (at_max),
        .enable        (enable),
        .reset_counter (reset_counter),
        .freeze        (freeze),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Clean press: debounced pulse lands 6 edges after the edge, FSM reacts on the 7th.
    task automatic press(input logic s, input logic l);
        if (s) key_start_n = 1'b0;
        if (l) key_lap_n   = 1'b0;
        step(7);
    endtask

    task automatic release_keys();
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        step(8);
    endtask

    initial begin
        rst         = 1'b1;
        key_start_n = 1'b1;
        key_lap_n   = 1'b1;
        at_max      = 1'b0;
        step(3);
        rst = 1'b0;
        check("reset_state",  state, 2'd0);
        check("reset_enable", {1'b0, enable}, 2'd0);
        check("reset_rstc",   {1'b0, reset_counter}, 2'd0);
        check("reset_freeze", {1'b0, freeze}, 2'd0);

        for (int i = 0; i < 10; i++) begin
            key_start_n = 1'b0;
            step(2);
            key_start_n = 1'b1;
            step(2);
        end
        step(10);
        check("bounce_state",  state, 2'd0);
        check("bounce_enable", {1'b0, enable}, 2'd0);

        key_start_n = 1'b0;
        step(6);
        check("start_latency_early", state, 2'd0);
        step(1);
        check("start_run_state",  state, 2'd1);
        check("start_run_enable", {1'b0, enable}, 2'd1);
        release_keys();

        press(1'b1, 1'b0);
        check("pause_state",  state, 2'd2);
        check("pause_enable", {1'b0, enable}, 2'd0);
        release_keys();

        press(1'b1, 1'b0);
        check("resume_state", state, 2'd1);
        release_keys();

        press(1'b0, 1'b1);
        check("lap1_freeze", {1'b0, freeze}, {1'b0, c_HOLD});
        check("lap1_state",  state, 2'd1);
        release_keys();
        press(1'b0, 1'b1);
        check("lap2_freeze", {1'b0, freeze}, 2'd0);
        release_keys();
        press(1'b0, 1'b1);
        check("lap3_freeze", {1'b0, freeze}, {1'b0, c_HOLD});
        release_keys();
        press(1'b1, 1'b0);
        check("pause_keeps_freeze", {1'b0, freeze}, {1'b0, c_HOLD});
        check("pause2_state", state, 2'd2);
        release_keys();

        press(1'b0, 1'b1);
        check("clear_state",  state, 2'd0);
        check("clear_rstc",   {1'b0, reset_counter}, 2'd1);
        check("clear_freeze", {1'b0, freeze}, 2'd0);
        step(1);
        check("clear_rstc_one_cycle", {1'b0, reset_counter}, 2'd0);
        release_keys();

        press(1'b0, 1'b1);
        check("idle_lap_state", state, 2'd0);
        check("idle_lap_rstc",  {1'b0, reset_counter}, 2'd1);
        step(1);
        check("idle_lap_rstc_end", {1'b0, reset_counter}, 2'd0);
        release_keys();

        press(1'b1, 1'b0);
        check("sat_run_state", state, 2'd1);
        release_keys();
        press(1'b0, 1'b1);
        release_keys();
        key_start_n = 1'b0;
        step(6);
        at_max = 1'b1;
        step(1);
        check("sat_done_state",  state, 2'd3);
        check("sat_done_enable", {1'b0, enable}, 2'd0);
        check("sat_done_freeze", {1'b0, freeze}, 2'd0);
        release_keys();
        press(1'b1, 1'b0);
        check("done_ignores_start", state, 2'd3);
        release_keys();
        press(1'b0, 1'b1);
        check("done_clear_state", state, 2'd0);
        check("done_clear_rstc",  {1'b0, reset_counter}, 2'd1);
        at_max = 1'b0;
        release_keys();

        press(1'b1, 1'b0);
        release_keys();
        press(1'b1, 1'b0);
        check("simul_pause_state", state, 2'd2);
        release_keys();
        press(1'b1, 1'b1);
        check("simul_state", state, 2'd0);
        check("simul_rstc",  {1'b0, reset_counter}, 2'd1);
        release_keys();

        press(1'b1, 1'b0);
        release_keys();
        press(1'b0, 1'b1);
        check("prereset_freeze", {1'b0, freeze}, {1'b0, c_HOLD});
        release_keys();
        key_lap_n = 1'b0;
        rst       = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_state",  state, 2'd0);
        check("midrst_enable", {1'b0, enable}, 2'd0);
        check("midrst_freeze", {1'b0, freeze}, 2'd0);
        check("midrst_rstc",   {1'b0, reset_counter}, 2'd0);
        step(6);
        check("held_lap_not_early", {1'b0, reset_counter}, 2'd0);
        step(1);
        check("held_lap_event", {1'b0, reset_counter}, 2'd1);
        step(1);
        check("held_lap_single", {1'b0, reset_counter}, 2'd0);
        step(20);
        check("held_lap_no_repeat", {1'b0, reset_counter}, 2'd0);
        check("held_lap_state", state, 2'd0);
        release_keys();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control FSM for the stopwatch datapath. It takes the two raw DE10-Lite push-buttons and the counter's saturation flag. It produces the count enable, the synchronous counter clear, and a lap-freeze strobe for the display path. It sits between the board keys and the time counter, in the 1 kHz clock domain.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 20: consecutive stable samples required to accept a key level (20 ms at 1 kHz); legal range 2..255.

Ports:
- clk  in  1  1 kHz clock, the same clock as the time counter
- rst  in  1  reset, synchronous and active-high
- key_start_n  in  1  raw KEY0, active-low, asynchronous; start/stop
- key_lap_n  in  1  raw KEY1, active-low, asynchronous; lap (while running) or clear (otherwise)
- at_max  in  1  from the counter; high while the count equals 59.999 s
- enable  out  1  count enable to the counter
- reset_counter  out  1  one-cycle synchronous clear pulse to the counter
- freeze  out  1  display holds its lap snapshot while high
- state  out  2  current FSM state, for LEDs

## Operation
- Key path, per key:
  - 2-flop synchronizer, followed by a debounce counter.
  - The accepted level changes only after DEBOUNCE_CYCLES consecutive samples differ from it.
  - A press event is a one-cycle pulse on the accepted released->pressed transition. The release transition generates no event.
- States and encodings: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.
- IDLE:
  - start press -> RUN.
  - lap press -> stay in IDLE and pulse reset_counter.
- RUN:
  - at_max -> DONE.
  - else start press -> PAUSE.
  - else lap press -> toggle freeze.
- PAUSE:
  - lap press -> IDLE, pulse reset_counter, clear freeze.
  - else start press -> RUN; freeze is unchanged.
- DONE:
  - lap press -> IDLE, pulse reset_counter.
  - start press is ignored.
- Outputs are Moore-decoded from registered state and flags:
  - enable = (state==RUN).
  - freeze is a register.
  - reset_counter is a register.
- Same-cycle events:
  - at_max beats every key event.
  - In PAUSE and DONE, a lap (clear) press beats a start press.
  - In RUN, a start press beats a lap press, and the lap press is dropped.
- Entering DONE clears freeze, so the final time is always displayed.
- Reset values: state=IDLE, enable=0, reset_counter=0, freeze=0, both synchronizer stages=1 (released), accepted levels=released, debounce counters=0.

## Timing
- Raw key edge to press pulse: 2 sync cycles + DEBOUNCE_CYCLES cycles, for a clean edge.
- Press pulse in cycle N -> state, enable and freeze update at the end of cycle N and are valid from cycle N+1.
- reset_counter is high for exactly cycle N+1.
- at_max high in cycle N while in RUN -> enable low from cycle N+1. At most one extra count is possible; the counter saturates, so this is harmless.
- Bounce shorter than DEBOUNCE_CYCLES produces no event.
- A key held through rst is accepted as pressed DEBOUNCE_CYCLES+2 cycles after rst deasserts and produces exactly one press event.
- rst asserted mid-operation:
  - All state returns to its reset values in the next cycle.
  - Any in-progress debounce count is discarded.
  - No reset_counter pulse is emitted, because the counter has its own reset.

## Configuration
- STOPWATCH_LAP_HOLD_EN defined:
  - The lap toggle in RUN drives freeze as described above.
- Not defined:
  - freeze is tied to 0.
  - A lap press in RUN is ignored.
  - All other transitions are unchanged.

## Structure
- Shared package stopwatch_pkg holds:
  - the sw_state_t enum with the four encodings above;
  - the DEBOUNCE_CYCLES default constant;
  - the at_max count constant 59999.
- One sub-module, key_debounce (synchronizer, debounce counter, press-pulse generator), instantiated once per key. The FSM stays in stopwatch_ctrl.

## Test plan
- Run/pause cycle (DEBOUNCE_CYCLES=4):
  - Stimulus: clean press on key_start_n.
  - Required: press pulse 6 cycles after the edge; enable=1 one cycle later; second press -> PAUSE (state=2'b10), enable=0.
- Bounce rejection:
  - Stimulus: key_start_n toggles every 2 cycles for 20 cycles, then stays released.
  - Required: no press event, state stays IDLE.
- Lap and clear:
  - Stimulus: in RUN, lap press.
  - Required: freeze=1 (with STOPWATCH_LAP_HOLD_EN); second lap press -> freeze=0.
  - Stimulus: start press, then lap press.
  - Required: state=IDLE, reset_counter high for exactly 1 cycle, freeze=0.
- Saturation:
  - Stimulus: assert at_max in RUN in the same cycle as a start press.
  - Required: state=DONE, enable=0; a later start press is ignored; lap press -> IDLE with reset_counter pulse.
- Simultaneous keys in PAUSE:
  - Stimulus: start and lap press events in the same cycle.
  - Required: IDLE with reset_counter pulse, not RUN.
- Reset mid-run:
  - Stimulus: rst for 1 cycle while in RUN with key_lap_n held low.
  - Required: state=IDLE, enable=0, freeze=0 next cycle; one lap press event DEBOUNCE_CYCLES+2 cycles after rst falls.
